counter_address_register_p: RTL and testbench

Parametrised successor of the 16-bit counter/address register. It is a WIDTH-bit register that can be loaded whole from the data bus or a byte at a time from the RHS bus. It counts up or down, adds a signed offset, and optionally saturates instead of wrapping. It drives its value onto the address bus, the data bus or (low byte) the RHS bus, and sits beside the PC/SP/transfer registers in the pipelined CPU. Tristate resolution happens at top level using the out/oe pairs.

---
 rtl/counter_address_register_p.sv | 122 ++++++++++++
 tb/tb_counter_address_register_p.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_address_register_p.sv
// counter_address_register_p
//   WIDTH-bit counter / address register for the pipelined CPU datapath.
//   It loads whole from the data bus or a byte at a time from the RHS bus.
//   It counts up or down, or adds a signed BYTE_W-bit offset. On overflow
//   it either wraps or saturates, and raises a sticky carry flag. Its value
//   is driven onto the address, data and RHS buses as out/oe pairs, and the
//   tristate resolution happens at top level.
//
// Ports
//   clock, clear                 rising-edge clock, async active-high reset
//   bus_in [WIDTH]               full-load source (load_n)
//   rhs_in [BYTE_W]              byte-load source (load_lo_n / load_hi_n)
//   offset [BYTE_W]              signed add operand (add_n)
//   load_n, load_lo_n, load_hi_n, add_n, inc_n, dec_n   update controls, active low
//   a_addr_n, a_bus_n, a_rhs_n   output-drive enables, active low
//   addr_out/addr_oe, bus_out/bus_oe, rhs_out/rhs_oe     bus drive pairs
//   value, zero, carry           register contents and flags
//
// WIDTH must equal 2*BYTE_W: the high-byte load writes rhs_in into
// value[WIDTH-1:BYTE_W].
module counter_address_register_p #(
    parameter int               WIDTH       = 16,
    parameter int               BYTE_W      = 8,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic [BYTE_W-1:0] rhs_in,
    input  logic [BYTE_W-1:0] offset,
    input  logic              load_n,
    input  logic              load_lo_n,
    input  logic              load_hi_n,
    input  logic              add_n,
    input  logic              inc_n,
    input  logic              dec_n,
    input  logic              a_addr_n,
    input  logic              a_bus_n,
    input  logic              a_rhs_n,
    output logic [WIDTH-1:0]  addr_out,
    output logic              addr_oe,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_oe,
    output logic [BYTE_W-1:0] rhs_out,
    output logic              rhs_oe,
    output logic [WIDTH-1:0]  value,
    output logic              zero,
    output logic              carry
);

    // The adder is two bits wider than the register. The extra top bit is
    // a sign bit. The bit below it catches carry-out. value + offset can
    // reach 2^WIDTH + 2^(BYTE_W-1) - 2, which does not fit in a signed
    // WIDTH+1 result.
    localparam int AW = WIDTH + 2;

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic [AW-1:0]    operand, sum;
    logic             arith, overflow, underflow;

    // Arithmetic operand select. add beats inc/dec. inc and dec together
    // cancel out, so the register holds.
    always_comb begin
        operand = '0;
        arith   = 1'b0;
        if (!add_n) begin
            operand = {{(AW-BYTE_W){offset[BYTE_W-1]}}, offset};
            arith   = 1'b1;
        end else if (inc_n ^ dec_n) begin
            operand = inc_n ? {AW{1'b1}} : AW'(1);
            arith   = 1'b1;
        end
    end

    assign sum       = {2'b00, value_q} + operand;
    assign underflow = sum[AW-1];
    assign overflow  = ~sum[AW-1] & sum[AW-2];

    always_comb begin
        value_d = value_q;
        carry_d = carry_q;
        if (!load_n) begin
            value_d = bus_in;
            carry_d = 1'b0;
        end else if (!load_lo_n || !load_hi_n) begin
            if (!load_lo_n) value_d[BYTE_W-1:0]     = rhs_in;
            if (!load_hi_n) value_d[WIDTH-1:BYTE_W] = rhs_in;
            carry_d = 1'b0;
        end else if (arith) begin
            carry_d = carry_q | overflow | underflow;
            if (SATURATE && overflow)       value_d = '1;
            else if (SATURATE && underflow) value_d = '0;
            else                            value_d = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            value_q <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    // The drives come from the registered value, so drive-and-update in
    // the same cycle shows the old value (post-increment semantics).
    assign addr_oe  = ~a_addr_n;
    assign bus_oe   = ~a_bus_n;
    assign rhs_oe   = ~a_rhs_n;
    assign addr_out = addr_oe ? value_q : '0;
    assign bus_out  = bus_oe  ? value_q : '0;
    assign rhs_out  = rhs_oe  ? value_q[BYTE_W-1:0] : '0;

    assign value = value_q;
    assign zero  = (value_q == '0);
    assign carry = carry_q;

endmodule

// File: tb/tb_counter_address_register_p.sv
// Bench for counter_address_register_p. Two instances share every input.
// One instance wraps and the other saturates. Each is checked against an
// integer-arithmetic reference model of the register's update rules.
module tb_counter_address_register_p;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [15:0] bus_in = '0;
    logic [7:0]  rhs_in = '0, offset = '0;
    logic        load_n = 1, load_lo_n = 1, load_hi_n = 1, add_n = 1, inc_n = 1, dec_n = 1;
    logic        a_addr_n = 1, a_bus_n = 1, a_rhs_n = 1;

    logic [15:0] w_addr, w_bus, w_value, s_addr, s_bus, s_value;
    logic [7:0]  w_rhs, s_rhs;
    logic        w_addr_oe, w_bus_oe, w_rhs_oe, w_zero, w_carry;
    logic        s_addr_oe, s_bus_oe, s_rhs_oe, s_zero, s_carry;

    // reference state: w = wrapping, s = saturating
    logic [15:0] mw, ms;
    logic        cw, cs;
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    counter_address_register_p #(.WIDTH(16), .BYTE_W(8), .SATURATE(1'b0)) dut_w (
        .clock(clock), .clear(clear), .bus_in(bus_in), .rhs_in(rhs_in), .offset(offset),
        .load_n(load_n), .load_lo_n(load_lo_n), .load_hi_n(load_hi_n), .add_n(add_n),
        .inc_n(inc_n), .dec_n(dec_n), .a_addr_n(a_addr_n), .a_bus_n(a_bus_n), .a_rhs_n(a_rhs_n),
        .addr_out(w_addr), .addr_oe(w_addr_oe), .bus_out(w_bus), .bus_oe(w_bus_oe),
        .rhs_out(w_rhs), .rhs_oe(w_rhs_oe), .value(w_value), .zero(w_zero), .carry(w_carry));

    counter_address_register_p #(.WIDTH(16), .BYTE_W(8), .SATURATE(1'b1)) dut_s (
        .clock(clock), .clear(clear), .bus_in(bus_in), .rhs_in(rhs_in), .offset(offset),
        .load_n(load_n), .load_lo_n(load_lo_n), .load_hi_n(load_hi_n), .add_n(add_n),
        .inc_n(inc_n), .dec_n(dec_n), .a_addr_n(a_addr_n), .a_bus_n(a_bus_n), .a_rhs_n(a_rhs_n),
        .addr_out(s_addr), .addr_oe(s_addr_oe), .bus_out(s_bus), .bus_oe(s_bus_oe),
        .rhs_out(s_rhs), .rhs_oe(s_rhs_oe), .value(s_value), .zero(s_zero), .carry(s_carry));

    // Reference update rule. The integer result is range-checked against
    // 0..65535 and then wrapped or clamped.
    function automatic void model_step(inout logic [15:0] v, inout logic c, input bit sat);
        int r, d;
        bit arith;
        arith = 1'b0;
        d = 0;
        if (!load_n) begin
            v = bus_in; c = 1'b0;
        end else if (!load_lo_n || !load_hi_n) begin
            if (!load_lo_n) v = {v[15:8], rhs_in};
            if (!load_hi_n) v = {rhs_in, v[7:0]};
            c = 1'b0;
        end else begin
            if (!add_n) begin d = int'($signed(offset)); arith = 1'b1; end
            else if (!inc_n && dec_n) begin d = 1; arith = 1'b1; end
            else if (inc_n && !dec_n) begin d = -1; arith = 1'b1; end
            if (arith) begin
                r = int'(v) + d;
                if (r > 65535) begin c = 1'b1; v = sat ? 16'hFFFF : 16'(r - 65536); end
                else if (r < 0) begin c = 1'b1; v = sat ? 16'h0000 : 16'(r + 65536); end
                else v = 16'(r);
            end
        end
    endfunction

    task automatic idle();
        load_n = 1; load_lo_n = 1; load_hi_n = 1; add_n = 1; inc_n = 1; dec_n = 1;
        a_addr_n = 1; a_bus_n = 1; a_rhs_n = 1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(mw, cw, 1'b0);
        model_step(ms, cs, 1'b1);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({w_value, w_carry, w_zero, s_value, s_carry} !== {16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL reset_state: got %h/%b/%b sat %h/%b, expected 0000/0/1", w_value, w_carry, w_zero, s_value, s_carry);
        end
        a_bus_n = 0; a_addr_n = 1; #1;
        checks++;
        if ({w_bus_oe, w_bus, w_addr_oe, w_addr} !== {1'b1, 16'h0000, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL reset_drive: got bus_oe=%b bus=%h addr_oe=%b addr=%h", w_bus_oe, w_bus, w_addr_oe, w_addr);
        end
        idle();
        clear = 0;
        mw = '0; ms = '0; cw = 0; cs = 0;
        // load 0x1234, then clear between edges
        load_n = 0; bus_in = 16'h1234; tick(); idle();
        checks++;
        if (w_value !== 16'h1234) begin errors++; $display("FAIL load_1234: got %h expected 1234", w_value); end
        inc_n = 0; #2; clear = 1; #1;
        checks++;
        if ({w_value, w_carry, s_value} !== {16'h0000, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL async_clear: got %h/%b sat %h, expected 0000/0", w_value, w_carry, s_value);
        end
        mw = '0; ms = '0; cw = 0; cs = 0;
        clear = 0;
        tick();
        checks++;
        if ({w_value, s_value} !== {16'h0001, 16'h0001}) begin
            errors++; $display("FAIL inc_after_clear: got %h sat %h, expected 0001", w_value, s_value);
        end
        idle();
    endtask

    task automatic test_loads();
        logic [15:0] exp [4];
        exp[0] = 16'hBEEF; exp[1] = 16'hBE12; exp[2] = 16'h3412; exp[3] = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin load_n = 0; bus_in = 16'hBEEF; end
                1: begin load_lo_n = 0; rhs_in = 8'h12; end
                2: begin load_hi_n = 0; rhs_in = 8'h34; end
                default: begin load_lo_n = 0; load_hi_n = 0; rhs_in = 8'h5A; end
            endcase
            tick();
            checks++;
            if ({w_value, s_value, w_carry} !== {exp[i], exp[i], 1'b0} || mw !== exp[i]) begin
                errors++; $display("FAIL load_step%0d: got %h sat %h carry %b, expected %h", i, w_value, s_value, w_carry, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_wrap_sat();
        load_n = 0; bus_in = 16'hFFFF; tick(); idle();
        inc_n = 0; tick(); idle();
        checks++;
        if ({w_value, w_carry, w_zero} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wrap_inc: got %h/%b/%b expected 0000/1/1", w_value, w_carry, w_zero);
        end
        checks++;
        if ({s_value, s_carry, s_zero} !== {16'hFFFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sat_inc: got %h/%b/%b expected ffff/1/0", s_value, s_carry, s_zero);
        end
        dec_n = 0; tick(); idle();
        checks++;
        if ({w_value, w_carry, s_value, s_carry} !== {16'hFFFF, 1'b1, 16'hFFFE, 1'b1}) begin
            errors++; $display("FAIL dec_sticky: got %h/%b sat %h/%b expected ffff/1 fffe/1", w_value, w_carry, s_value, s_carry);
        end
        load_n = 0; bus_in = 16'hFFFE; tick(); idle();
        checks++;
        if ({w_carry, s_carry} !== 2'b00) begin errors++; $display("FAIL load_clears_carry: got %b%b expected 00", w_carry, s_carry); end
        add_n = 0; offset = 8'h05; tick(); idle();
        checks++;
        if ({s_value, s_carry, w_value, w_carry} !== {16'hFFFF, 1'b1, 16'h0003, 1'b1}) begin
            errors++; $display("FAIL add_overflow: got sat %h/%b wrap %h/%b expected ffff/1 0003/1", s_value, s_carry, w_value, w_carry);
        end
        load_n = 0; bus_in = 16'h0003; tick(); idle();
        add_n = 0; offset = 8'hF8; tick(); idle();
        checks++;
        if ({s_value, s_carry, s_zero, w_value, w_carry} !== {16'h0000, 1'b1, 1'b1, 16'hFFFB, 1'b1}) begin
            errors++; $display("FAIL add_underflow: got sat %h/%b/%b wrap %h/%b expected 0000/1/1 fffb/1", s_value, s_carry, s_zero, w_value, w_carry);
        end
    endtask

    task automatic test_post_inc();
        load_n = 0; bus_in = 16'h2000; tick(); idle();
        a_addr_n = 0; inc_n = 0; #1;
        checks++;
        if ({w_addr_oe, w_addr} !== {1'b1, 16'h2000}) begin errors++; $display("FAIL post_inc_old: got %b/%h expected 1/2000", w_addr_oe, w_addr); end
        tick(); inc_n = 1; a_rhs_n = 0; #1;
        checks++;
        if ({w_addr, w_rhs_oe, w_rhs, w_bus_oe, w_bus} !== {16'h2001, 1'b1, 8'h01, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL post_inc_new: got addr %h rhs %b/%h bus %b/%h expected 2001 1/01 0/0000", w_addr, w_rhs_oe, w_rhs, w_bus_oe, w_bus);
        end
        idle();
    endtask

    task automatic test_priority();
        load_n = 0; add_n = 0; inc_n = 0; bus_in = 16'h0100; offset = 8'h7F; tick(); idle();
        checks++;
        if ({w_value, s_value} !== {16'h0100, 16'h0100}) begin errors++; $display("FAIL priority_load: got %h expected 0100", w_value); end
        inc_n = 0; dec_n = 0; tick(); idle();
        checks++;
        if ({w_value, s_value} !== {16'h0100, 16'h0100}) begin errors++; $display("FAIL inc_dec_hold: got %h expected 0100", w_value); end
    endtask

    task automatic test_random();
        logic [15:0] picks [5];
        for (int i = 0; i < 400; i++) begin
            picks[0] = 16'h0000; picks[1] = 16'h0001; picks[2] = 16'hFFFF; picks[3] = 16'hFFFE;
            picks[4] = 16'($urandom);
            load_n    = ($urandom_range(0, 9) != 0);
            load_lo_n = ($urandom_range(0, 9) != 0);
            load_hi_n = ($urandom_range(0, 9) != 0);
            add_n     = ($urandom_range(0, 2) != 0);
            inc_n     = $urandom_range(0, 1);
            dec_n     = $urandom_range(0, 1);
            a_addr_n  = $urandom_range(0, 1);
            a_bus_n   = $urandom_range(0, 1);
            a_rhs_n   = $urandom_range(0, 1);
            bus_in    = picks[$urandom_range(0, 4)];
            rhs_in    = 8'($urandom);
            offset    = 8'($urandom);
            #1;
            checks++;
            if ({w_addr, w_bus, w_rhs, s_addr, s_bus, s_rhs} !==
                {a_addr_n ? 16'h0 : mw, a_bus_n ? 16'h0 : mw, a_rhs_n ? 8'h0 : mw[7:0],
                 a_addr_n ? 16'h0 : ms, a_bus_n ? 16'h0 : ms, a_rhs_n ? 8'h0 : ms[7:0]}) begin
                errors++; $display("FAIL rand_drive[%0d]: got addr %h/%h rhs %h, model %h/%h", i, w_addr, s_addr, w_rhs, mw, ms);
            end
            tick();
            checks++;
            if ({w_value, w_carry, w_zero, s_value, s_carry, s_zero} !==
                {mw, cw, (mw == 16'h0), ms, cs, (ms == 16'h0)}) begin
                errors++; $display("FAIL rand_state[%0d]: got %h/%b/%b sat %h/%b/%b, expected %h/%b sat %h/%b",
                                   i, w_value, w_carry, w_zero, s_value, s_carry, s_zero, mw, cw, ms, cs);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_wrap_sat();
        test_post_inc();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
